// File: rtl/phys_reg_ready_table_if.sv
// Bundle of the rename/wakeup signals seen by the physical register ready table.
// Each phys_reg field is packed as {valid, reg_id}; the valid bit is the MSB.
interface phys_reg_ready_table_if #(
   parameter int SIZE_PHYSICAL     = 96,
   parameter int SIZE_PHYSICAL_LOG = 7,
   parameter int NUM_LANES         = 5,
   parameter int DISPATCH_WIDTH    = 4
);
   logic [NUM_LANES-1:0][SIZE_PHYSICAL_LOG:0]          wakeupTag_i;
   logic [SIZE_PHYSICAL_LOG:0]                         loadWbTag_i;
   logic [DISPATCH_WIDTH-1:0][SIZE_PHYSICAL_LOG:0]     allocDest_i;
   logic                                               recoverFlag_i;
   logic [2*DISPATCH_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] srcTag_i;
   logic [2*DISPATCH_WIDTH-1:0]                        srcReady_o;
   logic [SIZE_PHYSICAL-1:0]                           readyVector_o;
   logic                                               protocolErr_o;

   modport master (
      output wakeupTag_i, loadWbTag_i, allocDest_i, recoverFlag_i, srcTag_i,
      input  srcReady_o, readyVector_o, protocolErr_o
   );

   modport slave (
      input  wakeupTag_i, loadWbTag_i, allocDest_i, recoverFlag_i, srcTag_i,
      output srcReady_o, readyVector_o, protocolErr_o
   );
endinterface

// File: rtl/phys_reg_ready_table.sv
// Physical register ready table: one ready bit per physical register, set by
// wakeup/load broadcasts, cleared by rename allocation, with bypassed source lookup.
module phys_reg_ready_table #(
   parameter int SIZE_PHYSICAL     = 96,
   parameter int SIZE_PHYSICAL_LOG = 7,
   parameter int NUM_LANES         = 5,
   parameter int DISPATCH_WIDTH    = 4
) (
   input logic                  clk,
   input logic                  reset,
   phys_reg_ready_table_if.slave bus
);

   localparam int NUM_BCAST = NUM_LANES + 1;
   localparam int NUM_SRC   = 2 * DISPATCH_WIDTH;

   logic [SIZE_PHYSICAL-1:0]                     ready_q;
   logic                                         err_q;
   logic [NUM_BCAST-1:0]                         bc_valid;
   logic [NUM_BCAST-1:0][SIZE_PHYSICAL_LOG-1:0]  bc_tag;
   logic [SIZE_PHYSICAL-1:0]                     set_vec;
   logic [SIZE_PHYSICAL-1:0]                     clr_vec;
   logic                                         dup_bcast;
   logic                                         redundant_bcast;
   logic [NUM_SRC-1:0]                           src_ready;

   // Wakeup lanes and the load writeback port are treated as one broadcast set.
   always_comb begin
      bc_valid = '0;
      bc_tag   = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         bc_valid[l] = bus.wakeupTag_i[l][SIZE_PHYSICAL_LOG];
         bc_tag[l]   = bus.wakeupTag_i[l][SIZE_PHYSICAL_LOG-1:0];
      end
      bc_valid[NUM_LANES] = bus.loadWbTag_i[SIZE_PHYSICAL_LOG];
      bc_tag[NUM_LANES]   = bus.loadWbTag_i[SIZE_PHYSICAL_LOG-1:0];
   end

   // Decoding against in-range indices only drops out-of-range tags for free.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 0; i < SIZE_PHYSICAL; i++) begin
         for (int b = 0; b < NUM_BCAST; b++) begin
            if (bc_valid[b] && (bc_tag[b] == SIZE_PHYSICAL_LOG'(i))) begin
               set_vec[i] = 1'b1;
            end
         end
         for (int a = 0; a < DISPATCH_WIDTH; a++) begin
            if (bus.allocDest_i[a][SIZE_PHYSICAL_LOG] &&
                (bus.allocDest_i[a][SIZE_PHYSICAL_LOG-1:0] == SIZE_PHYSICAL_LOG'(i))) begin
               clr_vec[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      dup_bcast = 1'b0;
      for (int a = 0; a < NUM_BCAST; a++) begin
         for (int b = a + 1; b < NUM_BCAST; b++) begin
            if (bc_valid[a] && bc_valid[b] && (bc_tag[a] == bc_tag[b])) begin
               dup_bcast = 1'b1;
            end
         end
      end
   end

   assign redundant_bcast = |(set_vec & ready_q & ~clr_vec);

   // Same-cycle broadcasts bypass into the lookup; same-cycle allocs deliberately do not.
   always_comb begin
      src_ready = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int i = 0; i < SIZE_PHYSICAL; i++) begin
            if (bus.srcTag_i[k] == SIZE_PHYSICAL_LOG'(i)) begin
               src_ready[k] = src_ready[k] | ready_q[i];
            end
         end
         for (int b = 0; b < NUM_BCAST; b++) begin
            if (bc_valid[b] && (bc_tag[b] == bus.srcTag_i[k])) begin
               src_ready[k] = 1'b1;
            end
         end
      end
   end

   // Alloc clears take priority over broadcast sets; recovery overrides both.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready_q <= '1;
         err_q   <= 1'b0;
      end else if (bus.recoverFlag_i) begin
         ready_q <= '1;
      end else begin
         ready_q <= (ready_q | set_vec) & ~clr_vec;
         err_q   <= err_q | redundant_bcast | dup_bcast;
      end
   end

   assign bus.srcReady_o    = src_ready;
   assign bus.readyVector_o = ready_q;
   assign bus.protocolErr_o = err_q;

endmodule

// File: tb/tb_phys_reg_ready_table.sv
// Directed bench for phys_reg_ready_table: a table of per-cycle vectors followed
// by hand-written reset and protocol-error sequences.
module tb_phys_reg_ready_table;

   localparam logic [7:0] NV = 8'h00;

   typedef struct {
      logic [4:0][7:0] wk;
      logic [7:0]      ld;
      logic [3:0][7:0] al;
      logic            rec;
      logic [6:0]      src;
      logic            exp_src;
      logic            chk_all;
      logic [6:0]      chk_tag;
      logic            exp_bit;
      logic            exp_err;
   } vec_t;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   vec_t vecs[12];

   phys_reg_ready_table_if #(
      .SIZE_PHYSICAL(96), .SIZE_PHYSICAL_LOG(7), .NUM_LANES(5), .DISPATCH_WIDTH(4)
   ) bus ();

   phys_reg_ready_table #(
      .SIZE_PHYSICAL(96), .SIZE_PHYSICAL_LOG(7), .NUM_LANES(5), .DISPATCH_WIDTH(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] v(input int t);
      return {1'b1, 7'(t)};
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t t);
      bus.wakeupTag_i   = t.wk;
      bus.loadWbTag_i   = t.ld;
      bus.allocDest_i   = t.al;
      bus.recoverFlag_i = t.rec;
      for (int k = 0; k < 8; k++) bus.srcTag_i[k] = t.src;
   endtask

   task automatic setIdle();
      bus.wakeupTag_i   = '0;
      bus.loadWbTag_i   = '0;
      bus.allocDest_i   = '0;
      bus.recoverFlag_i = 1'b0;
      bus.srcTag_i      = '0;
   endtask

   task automatic setSrc(input int t);
      for (int k = 0; k < 8; k++) bus.srcTag_i[k] = 7'(t);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      vecs[0]  = '{'0, NV, {NV,NV,NV,v(40)}, 1'b0, 7'd40, 1'b1, 1'b0, 7'd40, 1'b0, 1'b0};
      vecs[1]  = '{'0, NV, '0, 1'b0, 7'd40, 1'b0, 1'b0, 7'd40, 1'b0, 1'b0};
      vecs[2]  = '{{NV,NV,v(40),NV,NV}, NV, '0, 1'b0, 7'd40, 1'b1, 1'b0, 7'd40, 1'b1, 1'b0};
      vecs[3]  = '{'0, v(17), {NV,NV,NV,v(17)}, 1'b0, 7'd17, 1'b1, 1'b0, 7'd17, 1'b0, 1'b0};
      vecs[4]  = '{'0, NV, {NV,v(7),v(6),v(5)}, 1'b0, 7'd5, 1'b1, 1'b0, 7'd5, 1'b0, 1'b0};
      vecs[5]  = '{'0, NV, {NV,NV,NV,v(8)}, 1'b1, 7'd6, 1'b0, 1'b1, 7'd8, 1'b1, 1'b0};
      vecs[6]  = '{'0, NV, {NV,NV,NV,v(100)}, 1'b0, 7'd100, 1'b0, 1'b1, 7'd0, 1'b1, 1'b0};
      vecs[7]  = '{{v(100),NV,NV,NV,NV}, NV, '0, 1'b0, 7'd100, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0};
      vecs[8]  = '{{NV,NV,NV,NV,8'h14}, NV, {NV,NV,NV,8'h14}, 1'b0, 7'd20, 1'b1, 1'b1, 7'd0, 1'b1, 1'b0};
      vecs[9]  = '{'0, NV, {NV,NV,NV,v(12)}, 1'b0, 7'd12, 1'b1, 1'b0, 7'd12, 1'b0, 1'b0};
      vecs[10] = '{{NV,NV,NV,v(30),NV}, NV, {NV,NV,NV,v(30)}, 1'b0, 7'd30, 1'b1, 1'b0, 7'd30, 1'b0, 1'b0};
      vecs[11] = '{{NV,NV,NV,NV,v(9)}, NV, '0, 1'b1, 7'd9, 1'b1, 1'b0, 7'd12, 1'b1, 1'b0};

      reset = 1'b0;
      setIdle();
      repeat (2) @(negedge clk);
      checkOutput("reset_vector", 128'(bus.readyVector_o), 128'({96{1'b1}}));
      checkOutput("reset_err", 128'(bus.protocolErr_o), 128'(0));
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d_src", i), 128'(bus.srcReady_o), 128'({8{vecs[i].exp_src}}));
         @(negedge clk);
         if (vecs[i].chk_all)
            checkOutput($sformatf("vec%0d_all", i), 128'(bus.readyVector_o), 128'({96{1'b1}}));
         else
            checkOutput($sformatf("vec%0d_bit", i), 128'(bus.readyVector_o[vecs[i].chk_tag]), 128'(vecs[i].exp_bit));
         checkOutput($sformatf("vec%0d_err", i), 128'(bus.protocolErr_o), 128'(vecs[i].exp_err));
      end

      // Two lanes waking the same not-ready tag: bit sets and the error flags.
      setIdle();
      bus.allocDest_i[0] = v(12);
      @(negedge clk);
      checkOutput("dup_pre_bit12", 128'(bus.readyVector_o[12]), 128'(0));
      setIdle();
      bus.wakeupTag_i[1] = v(12);
      bus.wakeupTag_i[3] = v(12);
      setSrc(12);
      #1;
      checkOutput("dup_src", 128'(bus.srcReady_o), 128'(8'hFF));
      @(negedge clk);
      checkOutput("dup_bit12", 128'(bus.readyVector_o[12]), 128'(1));
      checkOutput("dup_err", 128'(bus.protocolErr_o), 128'(1));

      setIdle();
      reset = 1'b0;
      #1;
      checkOutput("rst1_err", 128'(bus.protocolErr_o), 128'(0));
      @(negedge clk);
      reset = 1'b1;

      // Waking an already-ready register is a sticky error until reset.
      bus.wakeupTag_i[0] = v(9);
      @(negedge clk);
      checkOutput("redund_err", 128'(bus.protocolErr_o), 128'(1));
      setIdle();
      repeat (3) @(negedge clk);
      checkOutput("redund_sticky", 128'(bus.protocolErr_o), 128'(1));
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rst2_err", 128'(bus.protocolErr_o), 128'(0));
      checkOutput("rst2_all", 128'(bus.readyVector_o), 128'({96{1'b1}}));
      @(negedge clk);
      reset = 1'b1;

      // Reset landing mid-operation discards the cycle's alloc.
      bus.allocDest_i[0] = v(50);
      @(negedge clk);
      checkOutput("mid_pre_bit50", 128'(bus.readyVector_o[50]), 128'(0));
      bus.allocDest_i[0] = v(51);
      bus.wakeupTag_i[0] = v(70);
      setSrc(51);
      reset = 1'b0;
      #1;
      checkOutput("mid_src51", 128'(bus.srcReady_o), 128'(8'hFF));
      setSrc(70);
      #1;
      checkOutput("mid_src70", 128'(bus.srcReady_o), 128'(8'hFF));
      @(negedge clk);
      checkOutput("mid_all", 128'(bus.readyVector_o), 128'({96{1'b1}}));
      bus.wakeupTag_i = '0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("post_bit51", 128'(bus.readyVector_o[51]), 128'(0));
      checkOutput("post_err", 128'(bus.protocolErr_o), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/phys_reg_ready_table.md
PHYS_REG_READY_TABLE -- requirements
Module: phys_reg_ready_table

Interface
REQ-001 SHALL have parameter SIZE_PHYSICAL, default 96: number of physical registers tracked.
REQ-002 SHALL have parameter SIZE_PHYSICAL_LOG, default 7: physical tag width.
REQ-003 SHALL have parameter NUM_LANES, default 5: wakeup broadcast lanes, one per RSR lane.
REQ-004 SHALL have parameter DISPATCH_WIDTH, default 4: renamed instructions per cycle; source query ports = 2*DISPATCH_WIDTH.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port wakeupTag_i  input  NUM_LANES x phys_reg  per-lane {valid, reg_id} broadcast from the RSR lanes.
REQ-008 SHALL have port loadWbTag_i  input  phys_reg  load writeback tag broadcast.
REQ-009 SHALL have port allocDest_i  input  DISPATCH_WIDTH x phys_reg  newly renamed destinations to mark not-ready.
REQ-010 SHALL have port recoverFlag_i  input  1  pipeline flush; marks every register ready.
REQ-011 SHALL have port srcTag_i  input  2*DISPATCH_WIDTH x SIZE_PHYSICAL_LOG  source operand tags of dispatching instructions.
REQ-012 SHALL have port srcReady_o  output  2*DISPATCH_WIDTH x 1  readiness per source query.
REQ-013 SHALL have port readyVector_o  output  SIZE_PHYSICAL  registered ready bits.
REQ-014 SHALL have port protocolErr_o  output  1  sticky wakeup-protocol violation flag.

Function
REQ-015 SHALL hold one ready bit per physical register in flops; readyVector_o drives those flops directly.
REQ-016 A broadcast SHALL be any valid wakeupTag_i lane or a valid loadWbTag_i; each sets its reg_id bit at the next rising edge.
REQ-017 Each valid allocDest_i SHALL clear its reg_id bit at the next rising edge.
REQ-018 When alloc and broadcast hit the same reg_id in one cycle, alloc SHALL win: bit ends 0.
REQ-019 recoverFlag_i=1 SHALL set all bits to 1 at the next edge, overriding all allocs and broadcasts that cycle.
REQ-020 srcReady_o[k] SHALL be combinational, zero latency: readyVector[srcTag_i[k]] OR any broadcast this cycle with reg_id == srcTag_i[k].
REQ-021 srcReady_o SHALL NOT factor in same-cycle allocDest_i; intra-group dependences are resolved by rename.
REQ-022 Out-of-range tags (>= SIZE_PHYSICAL) SHALL be ignored on writes; srcReady_o for them SHALL be 0 unless a broadcast matches.
REQ-023 protocolErr_o SHALL set at the next edge, then hold until reset, when no recovery is in progress and a broadcast targets a bit already 1 that is not being allocated in the same cycle.
REQ-024 protocolErr_o SHALL also set, same conditions, when two or more broadcasts in one cycle carry the same reg_id.
REQ-025 Invalid (valid=0) inputs SHALL have no effect regardless of reg_id.
REQ-026 All state updates SHALL be single-cycle; no internal pipelining, no stall input.

Reset
REQ-027 While reset=0, all ready bits SHALL be 1 immediately (asynchronously) and protocolErr_o SHALL be 0.
REQ-028 Reset assertion mid-operation SHALL discard same-cycle allocs and broadcasts; srcReady_o then reflects all-ready plus live broadcasts.
REQ-029 The first edge after reset deassertion SHALL apply inputs normally.

Verification
REQ-030 Reset, then alloc tag 40 -> readyVector_o[40]=0 next cycle; srcTag_i[0]=40 -> srcReady_o[0]=0.
REQ-031 Tag 40 not ready, lane 2 broadcasts 40 -> srcReady_o[0]=1 same cycle; readyVector_o[40]=1 next cycle; protocolErr_o=0.
REQ-032 Same cycle: alloc 17 and loadWbTag 17 -> readyVector_o[17]=0 next cycle.
REQ-033 Tags 5, 6, 7 not ready, recoverFlag_i=1 with alloc 8 -> all 96 bits 1 next cycle.
REQ-034 Tag 9 ready, lane 0 broadcasts 9 -> protocolErr_o=1 next cycle, stays 1 until reset=0.
REQ-035 Lanes 1 and 3 both broadcast not-ready tag 12 -> readyVector_o[12]=1 and protocolErr_o=1 next cycle.
